// File: rtl/yoda_digits_pkg.sv
// Shared digit codes, sizes and FSM states for the binary-to-digits path.
// The seven-segment decoder imports this package too, so the codes agree.
package yoda_digits_pkg;

  localparam int VALUE_W    = 20;
  localparam int NUM_DIGITS = 7;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [4:0] DIGIT_MINUS = 5'h10;
  localparam logic [4:0] DIGIT_BLANK = 5'h1F;

  localparam logic [4:0] SHIFT_LAST = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  // Double-dabble correction for one BCD nibble
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin_to_digits.sv
// Serial 20-bit binary to seven display digits (double dabble),
// with optional sign and leading-zero blanking.
module bin_to_digits
  import yoda_digits_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  input  logic               is_signed,
  input  logic               blank_en,
  output logic               busy,
  output logic               done,
  output logic [4:0]         digits [0:NUM_DIGITS-1]
);

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic [VALUE_W-1:0] r_mag;
  logic               r_neg;
  logic               r_blank;
  logic               r_done;
  logic [4:0]         r_digits [0:NUM_DIGITS-1];

  logic               w_neg;
  logic [VALUE_W-1:0] w_mag;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [4:0]         w_fmt [0:NUM_DIGITS-1];

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign digits = r_digits;

  // -524288 negates to itself, which is the right 20-bit magnitude
  assign w_neg = is_signed && value[VALUE_W-1];
  assign w_mag = w_neg ? {VALUE_W{1'b0}} - value : value;

  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_bcd_adj[4*i +: 4] = add3(r_bcd[4*i +: 4]);
  end

  always_comb begin
    logic [3:0] w_nib;
    logic       w_hz;
    w_fmt = '{default: DIGIT_BLANK};
    w_hz  = 1'b1;
    w_nib = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_nib = r_bcd[4*i +: 4];
      w_hz  = w_hz && (w_nib == 4'd0);
      if (r_blank && w_hz && i != 0)
        w_fmt[i] = DIGIT_BLANK;
      else
        w_fmt[i] = {1'b0, w_nib};
    end
    // Minus sits on the blank/non-blank boundary, else far left
    if (r_neg) begin
      if (!r_blank) begin
        w_fmt[NUM_DIGITS-1] = DIGIT_MINUS;
      end else begin
        for (int i = NUM_DIGITS - 1; i >= 1; i--)
          if (w_fmt[i] == DIGIT_BLANK &&
              w_fmt[i-1] != DIGIT_BLANK)
            w_fmt[i] = DIGIT_MINUS;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (r_cnt == SHIFT_LAST) w_next = FORMAT;
      FORMAT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_mag    <= '0;
      r_neg    <= 1'b0;
      r_blank  <= 1'b0;
      r_done   <= 1'b0;
      r_digits <= '{default: DIGIT_BLANK};
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mag   <= w_mag;
            r_neg   <= w_neg;
            r_blank <= blank_en;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
          r_cnt          <= r_cnt + 5'd1;
        end
        FORMAT: begin
          r_digits <= w_fmt;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_digits.sv
// Directed bench for bin_to_digits: latency, busy width,
// blanking/sign formatting, ignored start and reset abort.
module tb_bin_to_digits;
  import yoda_digits_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] value;
  logic        is_signed;
  logic        blank_en;
  logic        busy;
  logic        done;
  logic [4:0]  digits [0:6];

  int vecs = 0;
  int errs = 0;

  localparam logic [4:0] BL = DIGIT_BLANK;
  localparam logic [4:0] MI = DIGIT_MINUS;
  localparam logic [34:0] ALL_BL = {BL, BL, BL, BL, BL, BL, BL};

  logic [34:0] last_exp;

  bin_to_digits dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .is_signed (is_signed),
    .blank_en  (blank_en),
    .busy      (busy),
    .done      (done),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] obs();
    return {digits[6], digits[5], digits[4], digits[3],
            digits[2], digits[1], digits[0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [34:0] o,
                     input logic [34:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic conv(input string tag,
                      input logic [19:0] v,
                      input logic s,
                      input logic b,
                      input logic poke,
                      input logic [34:0] e);
    int nbusy;
    nbusy = 0;
    @(negedge clk);
    value = v; is_signed = s; blank_en = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".done_e1"}, 35'(done), 35'd0);
    if (busy) nbusy++;
    for (int k = 2; k <= 21; k++) begin
      if (poke && k == 5) begin
        @(negedge clk);
        value = 20'd99; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) nbusy++;
    end
    chk({tag, ".done_e21"}, 35'(done), 35'd0);
    chk({tag, ".hold"}, obs(), last_exp);
    @(posedge clk); #1;
    if (busy) nbusy++;
    chk({tag, ".done_e22"}, 35'(done), 35'd1);
    chk({tag, ".busy_cyc"}, 35'(nbusy), 35'd21);
    chk({tag, ".digits"}, obs(), e);
    last_exp = e;
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; value = '0;
    is_signed = 1'b0; blank_en = 1'b0;
    last_exp = ALL_BL;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 35'(busy), 35'd0);
    chk("rst.done", 35'(done), 35'd0);
    chk("rst.digits", obs(), ALL_BL);
    @(negedge clk);
    reset = 1'b0;

    conv("u1234_bl", 20'd1234, 1'b0, 1'b1, 1'b1,
         {BL, BL, BL, 5'd1, 5'd2, 5'd3, 5'd4});
    conv("u1234_nb", 20'd1234, 1'b0, 1'b0, 1'b0,
         {5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd4});
    conv("umax", 20'd1048575, 1'b0, 1'b0, 1'b0,
         {5'd1, 5'd0, 5'd4, 5'd8, 5'd5, 5'd7, 5'd5});
    conv("s_m123_bl", 20'hFFF85, 1'b1, 1'b1, 1'b0,
         {BL, BL, BL, MI, 5'd1, 5'd2, 5'd3});
    conv("s_m123_nb", 20'hFFF85, 1'b1, 1'b0, 1'b0,
         {MI, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3});
    conv("u_fff85", 20'hFFF85, 1'b0, 1'b1, 1'b0,
         {5'd1, 5'd0, 5'd4, 5'd8, 5'd4, 5'd5, 5'd3});
    conv("smin_bl", 20'h80000, 1'b1, 1'b1, 1'b0,
         {MI, 5'd5, 5'd2, 5'd4, 5'd2, 5'd8, 5'd8});
    conv("smin_nb", 20'h80000, 1'b1, 1'b0, 1'b0,
         {MI, 5'd5, 5'd2, 5'd4, 5'd2, 5'd8, 5'd8});
    conv("zero_bl", 20'd0, 1'b0, 1'b1, 1'b0,
         {BL, BL, BL, BL, BL, BL, 5'd0});

    // abort: start 42, stray start 99 at edge 5, reset at edge 10
    @(negedge clk);
    value = 20'd42; is_signed = 1'b0; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    value = 20'd99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort.busy_e5", 35'(busy), 35'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy_rst", 35'(busy), 35'd0);
    chk("abort.digits_rst", obs(), ALL_BL);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort.no_done", 35'(ndone), 35'd0);
    chk("abort.digits", obs(), ALL_BL);
    last_exp = ALL_BL;

    // reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; value = 20'd5;
    @(posedge clk); #1;
    chk("rst_prio.busy", 35'(busy), 35'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;

    conv("after_abort7", 20'd7, 1'b0, 1'b1, 1'b0,
         {BL, BL, BL, BL, BL, BL, 5'd7});
    @(posedge clk); #1;
    chk("pulse_width", 35'(done), 35'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bin_to_digits.md
BIN_TO_DIGITS -- requirements
Module: bin_to_digits

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-004 SHALL have port value, input, 20 bits: the binary number to convert.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 means value is two's complement; 0 means value is unsigned.
REQ-006 SHALL have port blank_en, input, 1 bit: 1 enables leading-zero blanking.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when digits updates.
REQ-009 SHALL have port digits, output, array [0:6] of 5 bits: display codes; digits[0] is the least significant, rightmost digit.

Function
REQ-010 SHALL use digit codes 0-9 for decimal values, DIGIT_MINUS=5'h10 and DIGIT_BLANK=5'h1F.
REQ-011 SHALL implement FSM states IDLE, SHIFT and FORMAT; busy SHALL be high exactly when the state is not IDLE.
REQ-012 SHALL accept start only in IDLE, as follows.
  - Capture value, is_signed and blank_en.
  - Load magnitude: |value| if is_signed and value[19]=1, otherwise value.
  - Clear the 28-bit BCD scratch register and the shift counter, then go to SHIFT.
REQ-013 SHALL ignore start asserted while busy, with no effect on the conversion in flight.
REQ-014 SHALL, on each SHIFT cycle, add 3 to every BCD nibble >=5, then shift {bcd, magnitude} left one bit (double dabble).
REQ-015 SHALL perform exactly 20 SHIFT cycles and then move to FORMAT.
REQ-016 SHALL, in FORMAT, register all seven digits at once, pulse done high for one cycle and return to IDLE.
REQ-017 SHALL have a latency of 22 edges: counting the edge that accepts start as edge 1, digits update and done rises at edge 22.
REQ-018 SHALL be able to accept a new start in the cycle done is high, which gives a back-to-back period of 22 cycles.
REQ-019 SHALL hold digits stable between done pulses; the display never sees intermediate scratch values.
REQ-020 SHALL apply blanking when blank_en=1.
  - Every zero digit above the most significant nonzero digit becomes DIGIT_BLANK.
  - digits[0] is never blanked, so value 0 displays "0".
REQ-021 SHALL mark negative inputs (is_signed=1 and value[19]=1) with a minus sign.
  - blank_en=1: DIGIT_MINUS goes in the position directly left of the most significant nonzero digit.
  - blank_en=0: DIGIT_MINUS goes in digits[6].
  - The magnitude is at most 524288, so digits[6] is always free.
REQ-022 SHALL convert the unsigned maximum 1048575 using all seven digits with no overflow.
REQ-023 SHALL convert the signed minimum -524288 correctly: magnitude 524288, with DIGIT_MINUS in digits[6].
REQ-024 SHALL compute the magnitude in 20 bits unsigned; 0 - 20'h80000 = 20'h80000 is the correct magnitude.

Reset
REQ-025 SHALL, while reset is high, force the following at the next edge:
  - state = IDLE, busy = 0, done = 0;
  - all digits = DIGIT_BLANK;
  - scratch and counter cleared.
REQ-026 SHALL, on reset during SHIFT or FORMAT, abort the conversion with no done pulse and never output a partial result.
REQ-027 SHALL give reset priority over start asserted in the same cycle.

Structure
REQ-028 SHALL place DIGIT_BLANK, DIGIT_MINUS, NUM_DIGITS=7, VALUE_W=20 and the FSM state typedef in the shared package yoda_digits_pkg.
REQ-029 SHALL reuse the same package in the seven-segment decoder so that the codes agree.
REQ-030 SHALL be a single module with no sub-module; the add-3 nibble correction SHALL be a package function.

Verification
REQ-031 SHALL verify: unsigned 1234, blank_en=1 -> digits[6:0] = BL,BL,BL,1,2,3,4; done at edge 22; busy high for exactly 21 cycles.
REQ-032 SHALL verify: unsigned 1048575, blank_en=0 -> 1,0,4,8,5,7,5.
REQ-033 SHALL verify: signed 20'hFFF85 (-123), blank_en=1 -> BL,BL,BL,MINUS,1,2,3.
REQ-034 SHALL verify: signed 20'h80000, blank_en=1 -> MINUS,5,2,4,2,8,8; the same input with blank_en=0 gives an identical result.
REQ-035 SHALL verify: value 0, blank_en=1 -> BL x6 followed by 0.
REQ-036 SHALL verify: start 42 is accepted; start 99 arrives at cycle 5 and is ignored; reset at cycle 10 gives no done and all digits BL; a new start 7 then gives BL x6,7 at edge 22.
